// File: rtl/ena_sched_pkg.sv
// ena_sched_pkg: shared types, default widths and helpers for enable-counter schedulers
package ena_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int CW_DEF = 4;
  localparam int LW_DEF = 3;
  function automatic logic [7:0] onehot(input int unsigned idx);
    onehot = 8'd1 << idx;
  endfunction
endpackage

// File: rtl/ena_scheduler_rr_pick.sv
// rr_pick: combinational round-robin selector, first set req bit at or after ptr with wrap
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   idx
);
  always_comb begin
    found = |req;
    idx = '0;
    // walk downward so the candidate closest to ptr is written last
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NREQ]) idx = IW'((int'(ptr) + k) % NREQ);
  end
endmodule

// File: rtl/ena_scheduler.sv
// ena_scheduler: round-robin burst scheduler driving a shared counter's ena, never past LIMIT
module ena_scheduler
  import ena_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CW    = CW_DEF,
  parameter int LW    = LW_DEF,
  parameter int LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*LW-1:0] len,
  input  logic [CW-1:0]    count,
  output logic             ena,
  output logic [NREQ-1:0]  grant,
  output logic             done,
  output logic             trunc,
  output logic             busy,
  output logic             sat
);
  localparam int IW = $clog2(NREQ);
  state_t          r_state;
  logic [IW-1:0]   r_ptr, r_owner;
  logic [LW-1:0]   r_rem;
  logic [NREQ-1:0] r_grant;
  logic            r_trunc;
  logic            w_found, w_own_req;
  logic [IW-1:0]   w_idx;
  logic [LW-1:0]   w_len;
  logic [7:0]      w_oh;
  rr_pick #(.NREQ(NREQ)) u_pick (.req(req), .ptr(r_ptr), .found(w_found), .idx(w_idx));
  assign w_len     = len[int'(w_idx)*LW +: LW];
  assign w_oh      = onehot(int'(w_idx));
  assign w_own_req = req[r_owner];
  assign sat       = count >= CW'(LIMIT);
  assign ena       = (r_state == RUN) && (r_rem != '0) && !sat && w_own_req;
  assign grant     = r_grant;
  assign done      = r_state == DONE;
  assign trunc     = r_trunc;
  assign busy      = r_state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_rem   <= '0;
      r_grant <= '0;
      r_trunc <= 1'b0;
    end else
      case (r_state)
        IDLE:
          if (w_found) begin
            r_owner <= w_idx;
            r_grant <= w_oh[NREQ-1:0];
            r_rem   <= w_len;
            r_trunc <= 1'b0;
            r_state <= (w_len == '0) ? DONE : RUN;
          end
        RUN: begin
          r_rem <= r_rem - LW'(ena);
          // abort and saturation both end early; otherwise the last increment ends the burst
          if (!w_own_req || sat || r_rem == LW'(1)) begin
            r_state <= DONE;
            r_trunc <= !w_own_req || sat;
          end
        end
        DONE: begin
          r_grant <= '0;
          r_trunc <= 1'b0;
          r_ptr   <= (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + IW'(1);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
endmodule

// File: tb/tb_ena_scheduler.sv
// tb_ena_scheduler: directed scoreboard bench for ena_scheduler driving a real 4-bit counter
module tb_ena_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [11:0] len = '0;
  logic [3:0]  count;
  logic        ena, done, trunc, busy, sat;
  logic [3:0]  grant;
  int          n_vec = 0;
  int          n_err = 0;
  logic        prev_done = 1'b0;

  typedef struct {logic [3:0] g; logic t; int n;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ena_scheduler dut (.clk(clk), .rst(rst), .req(req), .len(len), .count(count),
                     .ena(ena), .grant(grant), .done(done), .trunc(trunc), .busy(busy), .sat(sat));

  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (ena) count <= count + 4'd1;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (ena) chk("prop_ena_below_limit", 32'(count < 4'd4), 1);
      chk("prop_count_le_limit", 32'(count <= 4'd4), 1);
      chk("prop_grant_onehot0", 32'($onehot0(grant)), 1);
      if (prev_done) chk("prop_done_not_back_to_back", 32'(done), 0);
      prev_done = done;
    end else prev_done = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    req = '0;
    len = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // drive a request, push the expected outcome, run until done and compare
  task automatic burst(input string tag, input logic [3:0] r, input logic [11:0] l,
                       input logic [3:0] g, input logic t, input int n);
    int  k = 0;
    bit  seen = 1'b0;
    exp_t e;
    req = r;
    len = l;
    sb.push_back('{g, t, n});
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (ena) k++;
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 1);
    e = sb.pop_front();
    chk({tag, "_grant"}, 32'(grant), 32'(e.g));
    chk({tag, "_trunc"}, 32'(trunc), 32'(e.t));
    chk({tag, "_ena_cycles"}, k, e.n);
    chk({tag, "_ena_in_done"}, 32'(ena), 0);
    req = '0;
  endtask

  initial begin
    exp_t e;
    #2;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_trunc", 32'(trunc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ena", 32'(ena), 0);
    do_rst();
    // single burst of 3
    burst("single", 4'b0001, 12'd3, 4'b0001, 1'b0, 3);
    chk("single_count", 32'(count), 3);
    step();
    chk("single_idle_grant", 32'(grant), 0);
    chk("single_idle_busy", 32'(busy), 0);
    // saturation: from count 3, only one increment allowed
    burst("sat", 4'b0010, 12'(4 << 3), 4'b0010, 1'b1, 1);
    chk("sat_count", 32'(count), 4);
    chk("sat_flag", 32'(sat), 1);
    step();
    // saturated counter still gets the handshake with trunc
    burst("sat_again", 4'b0100, 12'(2 << 6), 4'b0100, 1'b1, 0);
    step();
    // round robin with zero lengths
    do_rst();
    req = 4'b1011;
    len = '0;
    sb.push_back('{4'b0001, 1'b0, 0});
    sb.push_back('{4'b0010, 1'b0, 0});
    sb.push_back('{4'b1000, 1'b0, 0});
    sb.push_back('{4'b0001, 1'b0, 0});
    for (int i = 0; i < 4; i++) begin
      step();
      e = sb.pop_front();
      chk("rr_done", 32'(done), 1);
      chk("rr_grant", 32'(grant), 32'(e.g));
      chk("rr_trunc", 32'(trunc), 32'(e.t));
      step();
      chk("rr_gap_busy", 32'(busy), 0);
      chk("rr_gap_grant", 32'(grant), 0);
    end
    req = '0;
    chk("rr_count_untouched", 32'(count), 0);
    // abort after two increments
    do_rst();
    req = 4'b0100;
    len = 12'(5 << 6);
    step();
    chk("abort_grant", 32'(grant), 4'b0100);
    chk("abort_ena1", 32'(ena), 1);
    step();
    chk("abort_ena2", 32'(ena), 1);
    step();
    req = '0;
    #1;
    chk("abort_ena_drop", 32'(ena), 0);
    chk("abort_count", 32'(count), 2);
    step();
    chk("abort_done", 32'(done), 1);
    chk("abort_trunc", 32'(trunc), 1);
    chk("abort_done_grant", 32'(grant), 4'b0100);
    step();
    chk("abort_idle_grant", 32'(grant), 0);
    chk("abort_count_hold", 32'(count), 2);
    burst("abort_ptr", 4'b1111, 12'd0, 4'b1000, 1'b0, 0);
    step();
    // reset mid-run restores the pointer
    do_rst();
    burst("pre_rst_move_ptr", 4'b0010, 12'd0, 4'b0010, 1'b0, 0);
    step();
    req = 4'b0100;
    len = 12'(4 << 6);
    step();
    step();
    step();
    chk("midrun_busy_before", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("midrun_grant", 32'(grant), 0);
    chk("midrun_ena", 32'(ena), 0);
    chk("midrun_busy", 32'(busy), 0);
    chk("midrun_done", 32'(done), 0);
    step();
    chk("midrun_no_done", 32'(done), 0);
    rst = 1'b0;
    burst("post_rst", 4'b0101, 12'(1 | (1 << 6)), 4'b0001, 1'b0, 1);
    step();
    // random property phase
    do_rst();
    for (int i = 0; i < 400; i++) begin
      req = 4'($urandom);
      len = 12'($urandom);
      if (($urandom % 4) != 0) step();
      else begin
        @(posedge clk);
        #1;
      end
    end
    req = '0;
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
